lfsr_checker: RTL and testbench

Serial PRBS checker for the 16-bit Fibonacci LFSR stream: taps 0/2/3/5, shift right, feedback into bit 15. The block receives the generator's output bit stream, one bit per qualified clock, where each bit is the LSB of the generator state before it shifts. It self-synchronises to that stream, then checks every following bit against a locally regenerated sequence and counts mismatches. It sits at the receive end of a link or loopback path and serves as the on-chip counterpart of the LFSR generator in BIST and link-test setups.

---
 rtl/lfsr_checker.sv | 126 ++++++++++++
 tb/tb_lfsr_checker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising checker for the 16-bit x^16+x^14+x^13+x^11+1 PRBS stream
// Define LFSR_CHECKER_BITCOUNT_EN to add the bit_count port and its saturating counter.
module lfsr_checker #(
    parameter int VERIFY_BITS = 16,
    parameter int LOSS_THRESH = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic                   clear,
    output logic                   locked,
    output logic                   err,
    output logic [COUNT_WIDTH-1:0] error_count
`ifdef LFSR_CHECKER_BITCOUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] bit_count
`endif
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

    localparam logic [7:0]             VERIFY_LAST = 8'(VERIFY_BITS - 1);
    localparam logic [7:0]             LOSS_LAST   = 8'(LOSS_THRESH - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = 1;

    state_t      state;
    logic [15:0] p;
    logic [4:0]  fill;
    logic [7:0]  vcnt;
    logic [7:0]  consec;

    logic        exp_bit;
    logic        mismatch;
    logic [15:0] p_hunt;
    logic [15:0] p_pred;

    // p[i] holds the stream bit i positions ahead, so the recurrence yields the next bit
    assign exp_bit  = p[0] ^ p[2] ^ p[3] ^ p[5];
    assign mismatch = bit_in ^ exp_bit;
    assign p_hunt   = {bit_in, p[15:1]};
    assign p_pred   = {exp_bit, p[15:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            p           <= '0;
            fill        <= '0;
            vcnt        <= '0;
            consec      <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
            error_count <= '0;
`ifdef LFSR_CHECKER_BITCOUNT_EN
            bit_count   <= '0;
`endif
        end else begin
            err <= 1'b0;
            if (bit_valid) begin
                case (state)
                    HUNT: begin
                        p <= p_hunt;
                        if (fill == 5'd15) begin
                            // An all-zero fill is the lockup state and would predict zeros forever
                            fill <= '0;
                            if (p_hunt != 16'h0000) begin
                                state <= VERIFY;
                                vcnt  <= '0;
                            end
                        end else begin
                            fill <= fill + 5'd1;
                        end
                    end
                    VERIFY: begin
                        p <= p_pred;
                        if (!mismatch) begin
                            if (vcnt == VERIFY_LAST) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                                consec <= '0;
                            end else begin
                                vcnt <= vcnt + 8'd1;
                            end
                        end else begin
                            state <= HUNT;
                            fill  <= '0;
                        end
                    end
                    LOCK: begin
                        p <= p_pred;
`ifdef LFSR_CHECKER_BITCOUNT_EN
                        if (bit_count != CNT_MAX) bit_count <= bit_count + CNT_ONE;
`endif
                        if (mismatch) begin
                            err <= 1'b1;
                            if (error_count != CNT_MAX) error_count <= error_count + CNT_ONE;
                            if (consec == LOSS_LAST) begin
                                state  <= HUNT;
                                fill   <= '0;
                                locked <= 1'b0;
                            end else begin
                                consec <= consec + 8'd1;
                            end
                        end else begin
                            consec <= '0;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        fill   <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clear) begin
                error_count <= '0;
`ifdef LFSR_CHECKER_BITCOUNT_EN
                bit_count   <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - self-checking bench for lfsr_checker against a sequence-history reference model
module tb_lfsr_checker;

    logic        clk;
    logic        rst;
    logic        bit_valid;
    logic        bit_in;
    logic        clear;
    logic        locked;
    logic        err;
    logic [15:0] error_count;
    logic        locked_s;
    logic        err_s;
    logic [3:0]  ec_s;
`ifdef LFSR_CHECKER_BITCOUNT_EN
    logic [15:0] bit_count;
    logic [3:0]  bc_s;
`endif

    lfsr_checker dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
        .locked(locked), .err(err), .error_count(error_count)
`ifdef LFSR_CHECKER_BITCOUNT_EN
        , .bit_count(bit_count)
`endif
    );

    // Narrow counters so saturation is reachable within the run
    lfsr_checker #(.COUNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
        .locked(locked_s), .err(err_s), .error_count(ec_s)
`ifdef LFSR_CHECKER_BITCOUNT_EN
        , .bit_count(bc_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: keeps the last 16 bits of the reference sequence, oldest first
    bit hist[$];
    int m_mode;
    int m_vc;
    int m_cons;
    bit m_locked;
    bit m_err;
    int m_ec_raw;
    int m_bc_raw;

    function automatic int sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_mode = 0; m_vc = 0; m_cons = 0;
        m_locked = 0; m_err = 0; m_ec_raw = 0; m_bc_raw = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        bit pred;
        bit allz;
        m_err = 0;
        if (v) begin
            if (m_mode == 0) begin
                hist.push_back(b);
                if (hist.size() == 16) begin
                    allz = 1;
                    foreach (hist[i]) if (hist[i]) allz = 0;
                    if (allz) hist.delete();
                    else begin m_mode = 1; m_vc = 0; end
                end
            end else begin
                pred = hist[0] ^ hist[2] ^ hist[3] ^ hist[5];
                hist.push_back(pred);
                void'(hist.pop_front());
                if (m_mode == 1) begin
                    if (b == pred) begin
                        m_vc++;
                        if (m_vc == 16) begin m_mode = 2; m_cons = 0; m_locked = 1; end
                    end else begin
                        m_mode = 0; hist.delete();
                    end
                end else begin
                    m_bc_raw++;
                    if (b != pred) begin
                        m_err = 1; m_ec_raw++; m_cons++;
                        if (m_cons == 4) begin m_mode = 0; hist.delete(); m_locked = 0; end
                    end else m_cons = 0;
                end
            end
        end
        if (c) begin m_ec_raw = 0; m_bc_raw = 0; end
    endtask

    logic [15:0] gstate;

    function automatic logic gen_next();
        logic o;
        o = gstate[0];
        gstate = {gstate[0] ^ gstate[2] ^ gstate[3] ^ gstate[5], gstate[15:1]};
        return o;
    endfunction

    task automatic step(input logic v, input logic b, input logic c);
        bit_valid = v; bit_in = b; clear = c;
        @(posedge clk);
        #1;
        model_step(v, b, c);
        chk("model_locked", locked, m_locked);
        chk("model_err", err, m_err);
        chk("model_error_count", error_count, sat(m_ec_raw, 16));
        chk("model_error_count_w4", ec_s, sat(m_ec_raw, 4));
`ifdef LFSR_CHECKER_BITCOUNT_EN
        chk("model_bit_count", bit_count, sat(m_bc_raw, 16));
        chk("model_bit_count_w4", bc_s, sat(m_bc_raw, 4));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic inv;
        logic clr;
        logic e_err;
        logic e_locked;
        int   e_ec;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rose;
        bit any_err;
        int vcount;
        int burst;
        logic v, inv, c, b;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4};

        bit_valid = 0; bit_in = 0; clear = 0; rst = 1'b1;
        #3;
        chk("reset_locked", locked, 0);
        chk("reset_err", err, 0);
        chk("reset_error_count", error_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Lock from generator seed, continuous valid
        gstate = 16'hACE1;
        for (int i = 1; i <= 1000; i++) begin
            step(1'b1, gen_next(), 1'b0);
            if (i == 16) chk("hunt_not_locked_16", locked, 0);
            if (i == 31) chk("not_locked_31", locked, 0);
            if (i == 32) chk("locked_32", locked, 1);
        end
        chk("seed_error_count", error_count, 0);
`ifdef LFSR_CHECKER_BITCOUNT_EN
        chk("seed_bit_count", bit_count, 968);
`endif

        // Single error, clear vs mismatch, loss of lock
        for (int i = 0; i < 11; i++) begin
            step(1'b1, gen_next() ^ tbl[i].inv, tbl[i].clr);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].e_locked);
            chk($sformatf("tbl%0d_error_count", i), error_count, tbl[i].e_ec);
        end

        // Relock 32 valid bits after loss (tbl[10] was the first)
        for (int i = 2; i <= 32; i++) begin
            step(1'b1, gen_next(), 1'b0);
            if (i == 31) chk("relock_not_31", locked, 0);
            if (i == 32) chk("relock_32", locked, 1);
        end

        // Async reset mid-LOCK, checked before any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_error_count", error_count, 0);
        chk("async_rst_error_count_w4", ec_s, 0);
`ifdef LFSR_CHECKER_BITCOUNT_EN
        chk("async_rst_bit_count", bit_count, 0);
`endif
        #1;
        rst = 1'b0;
        model_reset();

        // All-zero stream never locks
        rose = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0);
            rose |= locked;
        end
        chk("zero_stream_never_locked", rose, 0);

        // Random non-LFSR stream
        rose = 0; any_err = 0;
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 1'($urandom_range(1, 0)), 1'b0);
            rose |= locked;
            any_err |= err;
        end
        chk("random_stream_never_locked", rose, 0);
        chk("random_stream_no_err", any_err, 0);

        // Half-rate valid gives the same results
        do_reset();
        gstate = 16'hACE1;
        vcount = 0;
        while (vcount < 1000) begin
            step(1'b1, gen_next(), 1'b0);
            vcount++;
            if (vcount == 31) chk("half_not_locked_31", locked, 0);
            if (vcount == 32) chk("half_locked_32", locked, 1);
            step(1'b0, 1'($urandom_range(1, 0)), 1'b0);
        end
        chk("half_error_count", error_count, 0);
`ifdef LFSR_CHECKER_BITCOUNT_EN
        chk("half_bit_count", bit_count, 968);
`endif

        // Randomised mix: gaps, sparse errors, error bursts, rare clears
        do_reset();
        gstate = 16'($urandom) | 16'h0001;
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            v = ($urandom_range(3, 0) != 0);
            c = ($urandom_range(1999, 0) == 0);
            inv = 1'b0;
            if (v) begin
                if (burst > 0) begin inv = 1'b1; burst--; end
                else if ($urandom_range(29, 0) == 0) inv = 1'b1;
                else if ($urandom_range(199, 0) == 0) burst = 4;
                b = gen_next() ^ inv;
            end else begin
                b = 1'($urandom_range(1, 0));
            end
            step(v, b, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
